// File: rtl/miniosii_cpu_debug_mon_access_pkg.sv
// miniosii_cpu_debug_mon_access_pkg: shared FSM states and jdo field positions for the debug monitor access stage
package miniosii_cpu_debug_mon_access_pkg;
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR_REQ} state_t;
    localparam int ADDR_LSB    = 17;
    localparam int RD_BIT      = 34;
    localparam int CLR_ERR_BIT = 35;
    localparam int WDATA_MSB   = 34;
    localparam int WDATA_LSB   = 3;
    function automatic logic is_req(state_t s);
        return s == RD_REQ || s == WR_REQ;
    endfunction
endpackage

// File: rtl/miniosii_cpu_debug_mon_access_wait_timer.sv
// miniosii_cpu_debug_mon_access_wait_timer: counts consecutive stalled request cycles and flags expiry
module miniosii_cpu_debug_mon_access_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    logic [7:0] count;
    assign expired = en && count == LAST;
    // advance on each stall, restart after acceptance or an abort
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) count <= '0;
        else count <= (clr || expired) ? '0 : en ? count + 8'd1 : count;
endmodule

// File: rtl/miniosii_cpu_debug_mon_access.sv
// miniosii_cpu_debug_mon_access: turns bridge strobes into monitor RAM word reads/writes with auto-increment and timeout
module miniosii_cpu_debug_mon_access
    import miniosii_cpu_debug_mon_access_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_waitrequest
);
    state_t state;
    logic   stall, accept, expired, any_strobe;
    assign stall      = is_req(state) && mem_waitrequest;
    assign accept     = is_req(state) && !mem_waitrequest;
    assign any_strobe = take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;

    miniosii_cpu_debug_mon_access_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .en      (stall),
        .expired (expired)
    );

    // command decode, request handshake, result capture and error tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            mem_addr      <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_wdata     <= '0;
        end else begin
            if (state != IDLE && any_strobe) monitor_error <= 1'b1;
            case (state)
                IDLE: begin
                    if (take_action_ocimem_a) begin
                        mem_addr <= jdo[ADDR_LSB +: ADDR_W];
                        if (jdo[CLR_ERR_BIT]) monitor_error <= 1'b0;
                        if (jdo[RD_BIT]) begin
                            state         <= RD_REQ;
                            mem_read      <= 1'b1;
                            monitor_ready <= 1'b0;
                        end
                    end else if (take_action_ocimem_b) begin
                        mem_wdata     <= jdo[WDATA_MSB:WDATA_LSB];
                        state         <= WR_REQ;
                        mem_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                    end else if (take_no_action_ocimem_a) begin
                        mem_addr      <= mem_addr + ADDR_W'(1);
                        state         <= RD_REQ;
                        mem_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        state    <= RD_DATA;
                    end else if (expired) begin
                        mem_read      <= 1'b0;
                        monitor_error <= 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                RD_DATA: begin
                    MonDReg       <= mem_rdata;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
                WR_REQ: begin
                    if (!mem_waitrequest) begin
                        mem_write     <= 1'b0;
                        mem_addr      <= mem_addr + ADDR_W'(1);
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end else if (expired) begin
                        mem_write     <= 1'b0;
                        monitor_error <= 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_miniosii_cpu_debug_mon_access.sv
// tb_miniosii_cpu_debug_mon_access: randomized command stream checked against a transaction-level monitor model
module tb_miniosii_cpu_debug_mon_access;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 6;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [37:0]       jdo = '0;
    logic              take_a = 1'b0, take_na = 1'b0, take_b = 1'b0;
    logic [31:0]       MonDReg;
    logic              monitor_ready, monitor_error;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read, mem_write;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic              mem_waitrequest = 1'b0;

    miniosii_cpu_debug_mon_access #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_na),
        .take_action_ocimem_b    (take_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .mem_addr                (mem_addr),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_wdata               (mem_wdata),
        .mem_rdata               (mem_rdata),
        .mem_waitrequest         (mem_waitrequest)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] ram [256];
    logic [31:0] exp_mem [256];
    logic [7:0]  m_addr = '0;
    logic        m_err = 1'b0;
    logic [31:0] m_mon = '0;

    int          stall_left = 0, stall_run = 0, rd_cnt = 0, wr_cnt = 0, req_cycles = 0;
    bit          hold = 0, prev_stall = 0;
    logic [7:0]  last_rd = '0, last_wr = '0, prev_addr = '0;
    logic [31:0] last_wd = '0, prev_wd = '0;
    logic [1:0]  prev_req = '0;

    task automatic tick();
        bit got_rd;
        got_rd = 0;
        @(negedge clk);
        if (mem_read || mem_write) req_cycles++;
        chk("one_req", 64'(mem_read & mem_write), 64'(0));
        if (prev_stall && stall_run < TIMEOUT) begin
            chk("stable_addr", 64'(mem_addr), 64'(prev_addr));
            chk("stable_wdata", 64'(mem_wdata), 64'(prev_wd));
            chk("stable_req", 64'({mem_read, mem_write}), 64'(prev_req));
        end
        if (mem_read || mem_write) begin
            if (stall_left > 0) begin
                mem_waitrequest = 1'b1;
                stall_left--;
                stall_run++;
                prev_stall = 1;
                prev_addr  = mem_addr;
                prev_wd    = mem_wdata;
                prev_req   = {mem_read, mem_write};
            end else begin
                mem_waitrequest = 1'b0;
                prev_stall = 0;
                stall_run  = 0;
                if (mem_write) begin
                    ram[mem_addr] = mem_wdata;
                    wr_cnt++;
                    last_wr = mem_addr;
                    last_wd = mem_wdata;
                end
                if (mem_read) begin
                    mem_rdata = ram[mem_addr];
                    hold   = 1;
                    got_rd = 1;
                    rd_cnt++;
                    last_rd = mem_addr;
                end
            end
        end else begin
            mem_waitrequest = 1'($urandom_range(0, 1));
            prev_stall = 0;
            stall_run  = 0;
        end
        if (!got_rd) begin
            if (hold) hold = 0;
            else mem_rdata = $urandom;
        end
    endtask

    function automatic logic [37:0] mk(input bit clr, input bit rd, input logic [7:0] ad);
        logic [37:0] j;
        j = {$urandom, $urandom};
        j[35] = clr;
        j[34] = rd;
        j[24:17] = ad;
        return j;
    endfunction

    task automatic cmd(input bit a, input bit b, input bit na, input logic [37:0] j,
                       input int stalls, input bit inject);
        bit          is_rd, is_wr, busy, tmo;
        int          exp_lat, rd0, wr0, rq0, n;
        logic [7:0]  req_addr;
        logic [31:0] wd;
        is_rd = 0;
        is_wr = 0;
        tmo   = stalls >= TIMEOUT;
        wd    = j[34:3];
        if (a) begin
            m_addr = j[24:17];
            if (j[35]) m_err = 0;
            is_rd = j[34];
        end else if (b) is_wr = 1;
        else if (na) begin
            m_addr = m_addr + 8'd1;
            is_rd  = 1;
        end
        req_addr = m_addr;
        busy     = is_rd || is_wr;
        exp_lat  = !busy ? 1 : tmo ? TIMEOUT + 1 : (is_rd ? 3 : 2) + stalls;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        rq0 = req_cycles;
        jdo = j;
        {take_a, take_b, take_na} = {a, b, na};
        stall_left = stalls;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (i == 1) begin
                {take_a, take_b, take_na} = 3'b000;
                if (inject && busy) begin
                    {take_a, take_b, take_na} = 3'($urandom_range(1, 7));
                    jdo = {$urandom, $urandom};
                end
            end
            if (i == 2) {take_a, take_b, take_na} = 3'b000;
            if (monitor_ready) begin
                n = i;
                break;
            end
        end
        {take_a, take_b, take_na} = 3'b000;
        if (busy && !tmo && is_rd) m_mon = exp_mem[req_addr];
        if (busy && !tmo && is_wr) begin
            exp_mem[req_addr] = wd;
            m_addr = m_addr + 8'd1;
        end
        if (busy && (tmo || inject)) m_err = 1;
        chk("latency", 64'(n), 64'(exp_lat));
        chk("ready", 64'(monitor_ready), 64'(1));
        chk("mondreg", 64'(MonDReg), 64'(m_mon));
        chk("error", 64'(monitor_error), 64'(m_err));
        chk("addr", 64'(mem_addr), 64'(m_addr));
        chk("req_idle", 64'({mem_read, mem_write}), 64'(0));
        chk("rd_count", 64'(rd_cnt - rd0), 64'(is_rd && !tmo));
        chk("wr_count", 64'(wr_cnt - wr0), 64'(is_wr && !tmo));
        chk("req_cycles", 64'(req_cycles - rq0), 64'(!busy ? 0 : tmo ? TIMEOUT : stalls + 1));
        if (is_rd && !tmo) chk("rd_addr", 64'(last_rd), 64'(req_addr));
        if (is_wr && !tmo) begin
            chk("wr_addr", 64'(last_wr), 64'(req_addr));
            chk("wr_data", 64'(last_wd), 64'(wd));
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_mondreg", 64'(MonDReg), 64'(0));
        chk("rst_ready", 64'(monitor_ready), 64'(1));
        chk("rst_error", 64'(monitor_error), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_req", 64'({mem_read, mem_write}), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
    endtask

    initial begin
        logic [37:0] j;
        int          wr0;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = $urandom;
            exp_mem[i] = ram[i];
        end
        ram[8'h10]     = 32'hDEADBEEF;
        exp_mem[8'h10] = 32'hDEADBEEF;
        repeat (3) tick();
        chk_reset_vals();
        reset_n = 1'b1;
        tick();
        chk_reset_vals();

        cmd(1, 0, 0, mk(0, 1, 8'h10), 0, 0);
        chk("deadbeef", 64'(MonDReg), 64'(32'hDEADBEEF));

        j = mk(0, 0, 8'h00);
        j[34:3] = 32'hCAFEF00D;
        cmd(0, 1, 0, j, 0, 0);
        chk("cafe_at_10", 64'(exp_mem[8'h10]), 64'(ram[8'h10]));
        cmd(0, 0, 1, j, 0, 0);
        chk("stream_addr", 64'(last_rd), 64'(8'h12));

        cmd(1, 0, 0, mk(1, 0, 8'hFF), 0, 0);
        cmd(0, 0, 1, mk(0, 0, 8'h00), 2, 0);
        chk("wrap_addr", 64'(last_rd), 64'(8'h00));
        chk("wrap_err", 64'(monitor_error), 64'(0));

        j = mk(0, 1, 8'h40);
        jdo = j;
        cmd(1, 0, 0, j, 5, 1);
        chk("busy_err", 64'(monitor_error), 64'(1));
        cmd(1, 0, 0, mk(1, 0, 8'h40), 0, 0);
        chk("busy_clr", 64'(monitor_error), 64'(0));

        cmd(0, 0, 1, mk(0, 0, 8'h00), TIMEOUT - 1, 0);
        cmd(0, 0, 1, mk(0, 0, 8'h00), TIMEOUT, 0);
        cmd(1, 0, 0, mk(1, 0, 8'h20), 0, 0);
        cmd(0, 1, 0, mk(0, 0, 8'h00), TIMEOUT + 3, 0);

        wr0 = wr_cnt;
        jdo = mk(0, 0, 8'h00);
        take_b = 1'b1;
        stall_left = 5;
        tick();
        take_b = 1'b0;
        tick();
        chk("pre_rst_write", 64'(mem_write), 64'(1));
        reset_n = 1'b0;
        #1;
        chk_reset_vals();
        prev_stall = 0;
        stall_left = 0;
        tick();
        reset_n = 1'b1;
        m_addr = '0;
        m_err  = 1'b0;
        m_mon  = '0;
        repeat (5) tick();
        chk("rst_no_write", 64'(wr_cnt - wr0), 64'(0));
        chk_reset_vals();

        for (int k = 0; k < 200; k++) begin
            logic [2:0] s;
            int         st;
            s  = 3'($urandom_range(1, 7));
            st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2))
                                             : int'($urandom_range(0, 3));
            cmd(s[2], s[1], s[0], mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom)),
                st, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
